// File: rtl/lut_layer_sched.sv
// lut_layer_sched: evaluates one layer of FANIN-input LUT neurons, one neuron per clock,
// through a single shared lookup fed from a registered read of the configuration store.
module lut_layer_sched #(
    parameter int FANIN       = 6,
    parameter int NUM_NEURONS = 32,
    parameter int IN_W        = 64,
    parameter int IDX_W       = $clog2(IN_W),
    parameter int NID_W       = $clog2(NUM_NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [NID_W-1:0]         cfg_neuron,
    input  logic [(1<<FANIN)-1:0]    cfg_tt,
    input  logic [FANIN*IDX_W-1:0]   cfg_conn,
    output logic                     cfg_ready,
    input  logic                     s_valid,
    input  logic [IN_W-1:0]          s_data,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [NUM_NEURONS-1:0]   m_data,
    input  logic                     m_ready,
    output logic                     busy
);
    localparam int TT_W   = 1 << FANIN;
    localparam int CONN_W = FANIN * IDX_W;
    localparam int CNT_W  = $clog2(NUM_NEURONS + 1);
    localparam int VEC_W  = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IN_W-1:0]        vec_q, vec_d;
    logic [NUM_NEURONS-1:0] m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic [TT_W-1:0]        tt_mem [NUM_NEURONS];
    logic [CONN_W-1:0]      conn_mem [NUM_NEURONS];
    logic [TT_W-1:0]        rd_tt_q, rd_tt_d;
    logic [CONN_W-1:0]      rd_conn_q, rd_conn_d;
    logic [VEC_W-1:0]       vec_ext;
    logic [FANIN-1:0]       addr;
    logic [NID_W-1:0]       rd_idx, wr_idx;
    logic                   cfg_wr;

    // Zero-extending the vector to the full index range makes out-of-range connections read 0.
    always_comb begin
        cfg_wr    = cfg_we && (state_q == IDLE);
        rd_idx    = cnt_q[NID_W-1:0];
        wr_idx    = NID_W'(cnt_q - CNT_W'(1));
        rd_tt_d   = tt_mem[rd_idx];
        rd_conn_d = conn_mem[rd_idx];
        vec_ext   = VEC_W'(vec_q);
        addr      = '0;
        for (int k = 0; k < FANIN; k++)
            addr[k] = vec_ext[rd_conn_q[k*IDX_W +: IDX_W]];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++)
            if (cfg_wr && cfg_neuron == NID_W'(i)) begin
                tt_mem[i]   <= cfg_tt;
                conn_mem[i] <= cfg_conn;
            end
        rd_tt_q   <= rd_tt_d;
        rd_conn_q <= rd_conn_d;
    end

    // Counter n reads neuron n and resolves neuron n-1 from the previous read.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        case (state_q)
            IDLE: if (s_valid) begin
                vec_d   = s_data;
                cnt_d   = '0;
                state_d = EVAL;
            end
            EVAL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q != '0)
                    m_data_d[wr_idx] = rd_tt_q[addr];
                if (cnt_q == CNT_W'(NUM_NEURONS)) begin
                    state_d   = OUT;
                    m_valid_d = 1'b1;
                end
            end
            OUT: if (m_ready) begin
                m_valid_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            vec_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec_q     <= vec_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign s_ready   = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
endmodule
